// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_valid;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       retire;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_valid, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_op,
               illegal_op, retire, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_valid, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_op,
               illegal_op, retire, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller: state register plus combinational decode
// of datapath controls from the current state, opcode, zero flag and mem_ready.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q;

    logic is_load, is_store, is_rtype, is_branch, is_itype, is_jal, supported;

    assign is_load   = (bus.opcode == 7'b0000011);
    assign is_store  = (bus.opcode == 7'b0100011);
    assign is_rtype  = (bus.opcode == 7'b0110011);
    assign is_branch = (bus.opcode == 7'b1100011);
    assign is_itype  = (bus.opcode == 7'b0010011);
    assign is_jal    = (bus.opcode == 7'b1101111);
    assign supported = is_load | is_store | is_rtype | is_branch | is_itype | is_jal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_q == StDecode) && !supported;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:    state_d = bus.mem_ready ? StDecode : StFetch;
            StDecode: begin
                if (is_load || is_store) state_d = StMemAdr;
                else if (is_rtype)       state_d = StExecR;
                else if (is_itype)       state_d = StExecI;
                else if (is_branch)      state_d = StBeq;
                else if (is_jal)         state_d = StJal;
                else                     state_d = StFetch;
            end
            StMemAdr:   state_d = is_store ? StMemWrite : StMemRead;
            StMemRead:  state_d = bus.mem_ready ? StMemWb : StMemRead;
            StMemWrite: state_d = bus.mem_ready ? StFetch : StMemWrite;
            StExecR, StExecI, StJal: state_d = StAluWb;
            // MEMWB, ALUWB, BEQ and the unused encodings 11-15 all return to fetch
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.imm_src    = 2'b00;
        bus.alu_op     = 2'b00;
        bus.retire     = 1'b0;
        case (state_q)
            StFetch: begin
                bus.mem_valid  = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            StDecode: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = is_jal ? 2'b11 : 2'b10;
            end
            StMemAdr: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = is_store ? 2'b01 : 2'b00;
            end
            StMemRead: begin
                bus.mem_valid = 1'b1;
                bus.adr_src   = 1'b1;
            end
            StMemWrite: begin
                bus.mem_valid = 1'b1;
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
                bus.retire    = bus.mem_ready;
            end
            StMemWb: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
                bus.retire     = 1'b1;
            end
            StAluWb: begin
                bus.reg_write = 1'b1;
                bus.retire    = 1'b1;
            end
            StExecR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
            end
            StExecI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b10;
            end
            StBeq: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
                bus.pc_write  = bus.zero;
                bus.retire    = 1'b1;
            end
            StJal: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_write  = 1'b1;
            end
            default: ;
        endcase
        // Reset holds the FETCH mux selects but must not launch any access or write
        if (rst) begin
            bus.pc_write  = 1'b0;
            bus.ir_write  = 1'b0;
            bus.mem_valid = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
            bus.retire    = 1'b0;
        end
    end

    assign bus.state      = state_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-002 The block SHALL have these inputs:
- opcode input 7: instruction-register bits [6:0].
- zero input 1: ALU zero flag.
- mem_ready input 1: memory accepts or completes the access this cycle.

REQ-003 The block SHALL have these outputs:
- pc_write output 1: PC register enable.
- adr_src output 1: memory address select (0 = PC, 1 = ALUOut).
- mem_valid output 1: memory access request.
- mem_write output 1: store strobe.
- ir_write output 1: instruction register enable.
- reg_write output 1: register file write enable.
- result_src output 2: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a output 2: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b output 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- imm_src output 2: immediate format select.
- alu_op output 2: ALU operation class for the ALU decoder.
- illegal_op output 1: registered pulse reporting an unsupported opcode.
- retire output 1: instruction-completion pulse.
- state output 4: current state encoding.

Function
REQ-004 The block SHALL implement the following states with fixed 4-bit encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10; encodings 11-15 SHALL go to FETCH on the next edge.
REQ-005 The block SHALL decode these opcodes: LOAD=0000011, STORE=0100011, R-type=0110011, BRANCH=1100011, I-type=0010011, JAL=1101111.
REQ-006 The block SHALL follow these state transitions:
- FETCH -> DECODE when mem_ready=1; otherwise it stays in FETCH.
- DECODE -> MEMADR for LOAD or STORE.
- DECODE -> EXECR for R-type, EXECI for I-type, BEQ for BRANCH, JAL for JAL.
- DECODE -> FETCH for any other opcode.

REQ-007 The block SHALL follow these further state transitions:
- MEMADR -> MEMREAD for LOAD, MEMWRITE for STORE.
- MEMREAD -> MEMWB when mem_ready=1, else it holds.
- MEMWRITE -> FETCH when mem_ready=1, else it holds.
- MEMWB, BEQ -> FETCH.
- EXECR, EXECI, JAL -> ALUWB; ALUWB -> FETCH.

REQ-008 Outputs SHALL be combinational functions of state, opcode, zero and mem_ready; any output not listed for a state SHALL be 0.
REQ-009 FETCH outputs SHALL be: mem_valid=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, ir_write=mem_ready, pc_write=mem_ready.
REQ-010 DECODE outputs SHALL be: alu_src_a=01, alu_src_b=01, alu_op=00, imm_src=11 when opcode is JAL, else 10.
REQ-011 MEMADR outputs SHALL be: alu_src_a=10, alu_src_b=01, alu_op=00, imm_src=01 for STORE, 00 for LOAD.
REQ-012 MEMREAD outputs SHALL be mem_valid=1, adr_src=1, result_src=00; MEMWRITE outputs SHALL be mem_valid=1, adr_src=1, mem_write=1, result_src=00; mem_write SHALL stay high throughout a stall.
REQ-013 MEMWB outputs SHALL be result_src=01, reg_write=1; ALUWB outputs SHALL be result_src=00, reg_write=1.
REQ-014 EXECR outputs SHALL be alu_src_a=10, alu_src_b=00, alu_op=10; EXECI outputs SHALL be alu_src_a=10, alu_src_b=01, imm_src=00, alu_op=10.
REQ-015 BEQ outputs SHALL be alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero.
REQ-016 JAL outputs SHALL be alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
REQ-017 retire SHALL be 1 in MEMWB, ALUWB, BEQ, and in MEMWRITE when mem_ready=1; it SHALL be 0 otherwise.
REQ-018 illegal_op SHALL be a flop set for exactly one cycle after a DECODE cycle with an unsupported opcode.
REQ-019 Instruction latency SHALL be, assuming mem_ready=1 throughout: LOAD 5 cycles, STORE 4, R-type 4, I-type 4, BRANCH 3, JAL 4; each mem_ready=0 cycle adds 1.
REQ-020 mem_ready SHALL be ignored in every state except FETCH, MEMREAD and MEMWRITE.

Reset
REQ-021 When rst is asserted, state SHALL go to FETCH and illegal_op to 0 asynchronously, including mid-instruction and mid-stall.
REQ-022 While rst=1, pc_write, ir_write, mem_valid, mem_write, reg_write and retire SHALL be forced to 0; mux selects SHALL show FETCH values.
REQ-023 After rst deasserts, the first edge with mem_ready=1 SHALL perform a fetch.

Verification
REQ-024 A bench SHALL cover these directed scenarios:
- LW, mem_ready=1 -> states 0,1,2,3,4; reg_write=1 and result_src=01 in state 4; retire pulses once.
- SW with mem_ready low for 2 cycles in MEMWRITE -> mem_write=1 for 3 cycles; retire only on the ready cycle; back to 0.
- BEQ with zero=1, then zero=0 -> pc_write=1, then pc_write=0 in state 9; alu_op=01.
- JAL -> imm_src=11 in DECODE; pc_write=1 in state 10; ALUWB reg_write=1; 4 cycles total.
- opcode 0000000 -> DECODE to FETCH; illegal_op=1 for one cycle; no write enables.
- rst asserted in MEMREAD -> immediate state=0; all enables 0 while rst=1.
